sram_write_arbiter: RTL
=======================

Name: sram_write_arbiter

Overview:
- Shares one Wishbone master write port to SRAM between NUM_CH fifo-drain channels.
- Each channel delivers 32-bit words with a one-cycle start pulse; the block latches the word and arbitrates round-robin.
- The winning word is written to its channel's circular SRAM region.
- The channel receives a one-cycle done pulse, which is the data_done handshake its drain state machine waits on.

Parameters:
NUM_CH, 2, number of requesting channels (2..4)
BUF_WORDS, 16, words per channel circular region; power of two, >=2
OFS_W, $clog2(BUF_WORDS), width of per-channel word offset counter

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  synchronous active-high reset
ch_start  in  NUM_CH  per-channel one-cycle write request pulse
ch_data  in  NUM_CH*32  per-channel write data, valid only in start cycle; channel i at [32*i+31:32*i]
ch_base  in  NUM_CH*32  per-channel region byte base address, static while channel active
ch_clear  in  NUM_CH  per-channel sync clear of offset and sticky flags
ch_done  out  NUM_CH  one-cycle pulse: channel's write finished (ack or err)
ch_wrap  out  NUM_CH  one-cycle pulse: channel offset wrapped BUF_WORDS-1 -> 0
ch_overrun  out  NUM_CH  sticky: start arrived while channel already pending
ch_err  out  NUM_CH  sticky: bus error on channel's write
wb_adr_o  out  32  master address
wb_dat_o  out  32  master write data
wb_sel_o  out  4  byte select, constant 4'hF during cycles
wb_we_o  out  1  write enable
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  slave ack
wb_err_i  in  1  slave error
busy  out  1  high when not IDLE or any channel pending

Behaviour:
- Reset values:
  - all outputs 0; pending, data latches and offsets 0.
  - round-robin pointer = NUM_CH-1, so channel 0 has first priority.
- Reset mid-write: cyc/stb/we drop on the next edge; no done pulse; the in-flight word is discarded.
- Capture:
  - ch_start[i] with pending[i]=0 sets pending[i] and latches ch_data[i] at that edge.
  - ch_start[i] with pending[i]=1: word dropped, ch_overrun[i] set, original latched word untouched.
- FSM IDLE -> WRITE -> IDLE. All bus outputs are registered.
- IDLE:
  - if any pending: grant the first pending channel after the rr pointer, cyclically.
  - load wb_adr_o = ch_base[g] + {offset[g],2'b00} (32-bit wraparound add), wb_dat_o = latched word.
  - assert cyc/stb/we with sel=F; go to WRITE; rr pointer = g.
- WRITE:
  - hold all bus outputs stable until wb_ack_i or wb_err_i is sampled high.
  - on that edge: deassert cyc/stb/we, clear pending[g], pulse ch_done[g] the next cycle, return to IDLE.
  - on ack: offset[g] increments modulo BUF_WORDS; ch_wrap[g] pulses in the same cycle as ch_done when the old offset was BUF_WORDS-1.
  - on err: offset unchanged, ch_err[g] set.
  - ack and err both high: treated as err.
- Latency:
  - start at cycle N -> pending at N+1 -> cyc/stb high at N+2.
  - ack at cycle M -> ch_done at M+1; the next grant's cyc/stb is high at M+2 at the earliest.
  - One idle bus cycle between transfers.
- A start arriving for the granted channel while its write is in WRITE is an overrun (pending still 1) and is not accepted.
- The cycle ch_done[i] is high, pending[i] is already 0, so a start in that cycle is accepted.
- ch_clear[i]:
  - zeroes offset[i], ch_overrun[i], ch_err[i]; does not affect pending or an in-flight write.
  - clear coincident with an ack for channel i: clear wins, offset = 0, no wrap pulse.
- Start and clear in the same cycle: the start is captured normally.
- A start with no competing requester is granted even if it matches the rr pointer.

Test Plan:
- Single write: ch_base0=0x1000, start0 data 0xDEADBEEF; slave acks 1 cycle after stb -> adr 0x1000, dat 0xDEADBEEF, sel F, cyc high 2 cycles, ch_done[0] one cycle after ack, offset0=1.
- Round-robin: ch0 and ch1 start same cycle, base 0x1000/0x2000 -> ch0 written first at 0x1000, then ch1 at 0x2000. Repeat with both pending -> ch0 second word at 0x1004 only after ch1, never twice in a row.
- Wrap: 17 sequential ch0 writes, BUF_WORDS=16 -> addresses 0x1000..0x103C then 0x1000. ch_wrap[0] pulses exactly once, with the 16th ch_done.
- Wait states and error: slave delays ack 5 cycles -> adr/dat/stb held stable throughout. Next write gets err -> ch_err[0]=1, ch_done[0] pulses, the retried word reuses the same address.
- Overrun: two ch1 starts 1 cycle apart, data 0x11 then 0x22 -> only 0x11 written, ch_overrun[1]=1. ch_clear[1] -> overrun 0, next address = ch_base1.
- Reset mid-cycle: wb_rst during WRITE with ack withheld -> cyc/stb 0 next cycle, no ch_done, pending cleared. A post-reset start to ch1 writes at ch_base1 + 0.

Source files
------------

// File: rtl/sram_write_arbiter_if.sv
// Wishbone write-master bus between the SRAM write arbiter and the SRAM slave.
interface sram_write_arbiter_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter sharing one Wishbone write port between NUM_CH fifo-drain
// channels, each writing into its own circular SRAM region.
module sram_write_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned BUF_WORDS = 16,
  parameter int unsigned OFS_W     = $clog2(BUF_WORDS)
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [NUM_CH-1:0]      ch_start,
  input  logic [NUM_CH*32-1:0]   ch_data,
  input  logic [NUM_CH*32-1:0]   ch_base,
  input  logic [NUM_CH-1:0]      ch_clear,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [NUM_CH-1:0]      ch_wrap,
  output logic [NUM_CH-1:0]      ch_overrun,
  output logic [NUM_CH-1:0]      ch_err,
  sram_write_arbiter_if.master   wb,
  output logic                   busy
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [31:0]       data_q [NUM_CH];
  logic [OFS_W-1:0]  offset [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   next_gnt;
  logic [CH_W-1:0]   cand;
  logic              next_vld;

  // First pending channel strictly after rr_ptr, wrapping back onto rr_ptr itself last.
  always_comb begin
    next_gnt = rr_ptr;
    next_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(rr_ptr) + k) % NUM_CH);
      if (!next_vld && pending[cand]) begin
        next_vld = 1'b1;
        next_gnt = cand;
      end
    end
  end

  assign busy = (state != IDLE) || (|pending);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state       <= IDLE;
      pending     <= '0;
      rr_ptr      <= CH_W'(NUM_CH - 1);
      gnt         <= '0;
      ch_done     <= '0;
      ch_wrap     <= '0;
      ch_overrun  <= '0;
      ch_err      <= '0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
        offset[i] <= '0;
      end
    end else begin
      ch_done <= '0;
      ch_wrap <= '0;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_start[i]) begin
          if (!pending[i]) begin
            pending[i] <= 1'b1;
            data_q[i]  <= ch_data[32*i +: 32];
          end else begin
            ch_overrun[i] <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (next_vld) begin
            wb.wb_adr_o <= ch_base[next_gnt*32 +: 32] + 32'({offset[next_gnt], 2'b00});
            wb.wb_dat_o <= data_q[next_gnt];
            wb.wb_sel_o <= 4'hF;
            wb.wb_we_o  <= 1'b1;
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            gnt         <= next_gnt;
            rr_ptr      <= next_gnt;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (wb.wb_ack_i || wb.wb_err_i) begin
            wb.wb_sel_o  <= '0;
            wb.wb_we_o   <= 1'b0;
            wb.wb_cyc_o  <= 1'b0;
            wb.wb_stb_o  <= 1'b0;
            pending[gnt] <= 1'b0;
            ch_done[gnt] <= 1'b1;
            state        <= IDLE;
            if (wb.wb_err_i) begin
              ch_err[gnt] <= 1'b1;
            end else if (!ch_clear[gnt]) begin
              offset[gnt] <= offset[gnt] + OFS_W'(1);
              if (offset[gnt] == '1) ch_wrap[gnt] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Clear is applied last so it overrides a same-cycle offset advance or flag set.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_clear[i]) begin
          offset[i]     <= '0;
          ch_overrun[i] <= 1'b0;
          ch_err[i]     <= 1'b0;
        end
      end
    end
  end

endmodule
